// File: rtl/tdm_demux_1to4.sv
// rtl/tdm_demux_1to4.sv - 1-to-4 TDM demultiplexer with frame alignment and optional realignment.
// Optional mid-frame realignment on frame_sync is enabled by defining DEMUX_SYNC_CHECK_EN.
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             vld_a,
    output logic             vld_b,
    output logic             vld_c,
    output logic             vld_d,
    output logic             frame_done,
    output logic             sync_err
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_out [4];
    logic [3:0]       r_vld;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_realign;
    logic [1:0]       w_route_slot;

    // Unaligned words are dropped until a frame_sync marks slot 0.
    assign w_accept = din_valid && ((r_state == ST_RUN) || frame_sync);

`ifdef DEMUX_SYNC_CHECK_EN
    logic r_sync_err;

    assign w_realign = din_valid && frame_sync && (r_state == ST_RUN) && (r_slot != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_realign;
        end
    end

    assign sync_err = r_sync_err;
`else
    assign w_realign = 1'b0;
    assign sync_err  = 1'b0;
`endif

    assign w_route_slot = ((r_state == ST_IDLE) || w_realign) ? 2'b00 : r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_slot       <= 2'b00;
            r_vld        <= 4'b0000;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_vld        <= 4'b0000;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_out[w_route_slot] <= din;
                r_vld[w_route_slot] <= 1'b1;
                r_frame_done        <= (w_route_slot == 2'b11);
                r_slot              <= w_route_slot + 2'd1;
                r_state             <= ST_RUN;
            end
        end
    end

    assign out_a      = r_out[0];
    assign out_b      = r_out[1];
    assign out_c      = r_out[2];
    assign out_d      = r_out[3];
    assign vld_a      = r_vld[0];
    assign vld_b      = r_vld[1];
    assign vld_c      = r_vld[2];
    assign vld_d      = r_vld[3];
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb/tb_tdm_demux_1to4.sv - scoreboard bench for tdm_demux_1to4 (DEMUX_SYNC_CHECK_EN aware).
module tb_tdm_demux_1to4;

`ifdef DEMUX_SYNC_CHECK_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic       vld_a, vld_b, vld_c, vld_d;
    logic       frame_done, sync_err;

    tdm_demux_1to4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .vld_a      (vld_a),
        .vld_b      (vld_b),
        .vld_c      (vld_c),
        .vld_d      (vld_d),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       fd;
        logic       se;
    } exp_t;

    exp_t       q[$];
    bit         m_run;
    logic [1:0] m_slot;
    logic [7:0] m_out [4];
    int         n_pass = 0;
    int         n_total = 0;

    wire [3:0]  w_vld  = {vld_d, vld_c, vld_b, vld_a};
    wire [31:0] w_outs = {out_d, out_c, out_b, out_a};

    task automatic model_reset();
        q.delete();
        m_run  = 1'b0;
        m_slot = 2'b00;
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    endtask

    // Drive one cycle of stimulus and push the expected result if the word is accepted.
    task automatic cyc(input logic v, input logic s, input logic [7:0] d);
        bit   accept, realign;
        int   rs;
        exp_t e;
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        accept  = v && (m_run || s);
        realign = accept && m_run && s && (m_slot != 2'b00) && SYNC_EN;
        if (accept) begin
            rs = (!m_run || realign) ? 0 : int'(m_slot);
            e.ch = rs; e.data = d; e.fd = (rs == 3); e.se = realign;
            q.push_back(e);
            m_out[rs] = d;
            m_slot    = 2'(rs + 1);
            m_run     = 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (w_vld != 4'b0000) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL sb_unexpected_vld got vld=%b required none", w_vld);
                end else begin
                    e = q.pop_front();
                    if (w_vld !== (4'b0001 << e.ch) || w_outs[e.ch*8 +: 8] !== e.data ||
                        frame_done !== e.fd || sync_err !== e.se)
                        $display("FAIL sb_word got vld=%b data=%h fd=%b se=%b required vld=%b data=%h fd=%b se=%b",
                                 w_vld, w_outs[e.ch*8 +: 8], frame_done, sync_err,
                                 4'b0001 << e.ch, e.data, e.fd, e.se);
                    else n_pass++;
                end
            end else begin
                n_total++;
                if (frame_done !== 1'b0 || sync_err !== 1'b0 || q.size() != 0)
                    $display("FAIL sb_idle got fd=%b se=%b pending=%0d required 0/0/0",
                             frame_done, sync_err, q.size());
                else n_pass++;
            end
            n_total++;
            if (w_outs !== {m_out[3], m_out[2], m_out[1], m_out[0]})
                $display("FAIL sb_hold got %h required %h", w_outs,
                         {m_out[3], m_out[2], m_out[1], m_out[0]});
            else n_pass++;
        end
    end

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if ({w_outs, w_vld, frame_done, sync_err} !== 38'h0)
            $display("FAIL reset_state got outs=%h vld=%b fd=%b se=%b required all 0",
                     w_outs, w_vld, frame_done, sync_err);
        else n_pass++;
    endtask

    task automatic test_basic_frame();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i == 0), words[i]);
            n_total++;
            if (w_vld !== (4'b0001 << i) || frame_done !== (i == 3))
                $display("FAIL basic_vld slot %0d got vld=%b fd=%b required vld=%b fd=%b",
                         i, w_vld, frame_done, 4'b0001 << i, i == 3);
            else n_pass++;
        end
        idle(2);
        n_total++;
        if (w_outs !== 32'h44332211 || w_vld !== 4'b0000)
            $display("FAIL basic_outs got %h vld=%b required 44332211 vld=0000", w_outs, w_vld);
        else n_pass++;
    endtask

    task automatic test_no_sync();
        do_reset();
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h66);
        cyc(1'b0, 1'b1, 8'h77);
        cyc(1'b1, 1'b0, 8'h78);
        idle(1);
        n_total++;
        if (w_outs !== 32'h0 || w_vld !== 4'b0000)
            $display("FAIL no_sync got outs=%h vld=%b required 0", w_outs, w_vld);
        else n_pass++;
    endtask

    task automatic test_gap();
        do_reset();
        cyc(1'b1, 1'b1, 8'hA1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'hEE);
            n_total++;
            if (w_vld !== 4'b0000)
                $display("FAIL gap_idle got vld=%b required 0000", w_vld);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 8'hA2);
        n_total++;
        if (out_b !== 8'hA2 || out_a !== 8'hA1 || vld_b !== 1'b1)
            $display("FAIL gap_land got a=%h b=%h vld_b=%b required a=a1 b=a2 vld_b=1", out_a, out_b, vld_b);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_back_to_back();
        int fd_cnt = 0;
        int se_cnt = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i % 4 == 0), 8'(i + 1));
            fd_cnt += int'(frame_done);
            se_cnt += int'(sync_err);
        end
        idle(1);
        n_total++;
        if (fd_cnt != 2 || se_cnt != 0 || w_outs !== 32'h08070605)
            $display("FAIL b2b got fd=%0d se=%0d outs=%h required fd=2 se=0 outs=08070605",
                     fd_cnt, se_cnt, w_outs);
        else n_pass++;
    endtask

    task automatic test_sync_err();
        do_reset();
        cyc(1'b1, 1'b1, 8'hC1);
        cyc(1'b1, 1'b0, 8'hC2);
        cyc(1'b1, 1'b1, 8'hC3);
        n_total++;
        if (SYNC_EN) begin
            if (sync_err !== 1'b1 || out_a !== 8'hC3 || vld_a !== 1'b1)
                $display("FAIL sync_realign got se=%b a=%h vld_a=%b required se=1 a=c3 vld_a=1",
                         sync_err, out_a, vld_a);
            else n_pass++;
        end else begin
            if (sync_err !== 1'b0 || out_c !== 8'hC3 || vld_c !== 1'b1)
                $display("FAIL sync_ignored got se=%b c=%h vld_c=%b required se=0 c=c3 vld_c=1",
                         sync_err, out_c, vld_c);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 8'hC4);
        n_total++;
        if (sync_err !== 1'b0 || (SYNC_EN ? out_b : out_d) !== 8'hC4)
            $display("FAIL sync_next got se=%b b=%h d=%h required se=0 and c4 on %s",
                     sync_err, out_b, out_d, SYNC_EN ? "b" : "d");
        else n_pass++;
        idle(1);
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b1, 1'b1, 8'hB1);
        cyc(1'b1, 1'b0, 8'hB2);
        rst_n = 1'b0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({w_outs, w_vld, frame_done, sync_err} !== 38'h0)
            $display("FAIL async_reset got outs=%h vld=%b fd=%b se=%b required all 0",
                     w_outs, w_vld, frame_done, sync_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'hB3);
        cyc(1'b1, 1'b0, 8'hB4);
        idle(1);
        n_total++;
        if (w_outs !== 32'h0 || w_vld !== 4'b0000)
            $display("FAIL async_after got outs=%h vld=%b required 0", w_outs, w_vld);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_frame();
        test_no_sync();
        test_gap();
        test_back_to_back();
        test_sync_err();
        test_async_reset();
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
